rand_instr_gen: RTL
===================

Name: rand_instr_gen

Overview:
- Hardware generator of legal random instruction streams for the multicycle RISC core. It is the writer side of the instruction-memory load path that the fetch stage and the reference model later read.
- It replaces offline-generated random program images. It loads N_INSTR words into instruction memory through a valid/ready write port.
- The last word is always a self-jump halt, so random programs terminate deterministically.

Parameters:
- N_INSTR, 200, total words written, including the final halt word; range 2..256.
- BASE_ADDR, 8'h00, first instruction-memory address written.
- SEED, 32'h0000_0001, reset value of the LFSR. A value of 0 is replaced by 1.
- Elaboration error if BASE_ADDR+N_INSTR > 256.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin generation; ignored unless IDLE
- busy  out  1  high in GEN and HALT states
- done  out  1  one-cycle pulse after the halt word is accepted
- wr_valid  out  1  write request to instruction memory
- wr_ready  in  1  memory accepts the word this cycle
- wr_addr  out  8  target PC address
- wr_data  out  32  instruction word
- wr_count  out  8  number of words accepted so far

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, wr_valid=0, wr_addr=BASE_ADDR, wr_data=0, wr_count=0, lfsr=SEED (0 forced to 1). Reset mid-operation aborts immediately with no partial-word completion.
- States:
  - IDLE: on start go to GEN. wr_addr=BASE_ADDR, wr_count=0. The LFSR is not reseeded, so successive runs differ.
  - GEN: wr_valid=1, wr_data=fmt(lfsr). On wr_valid&&wr_ready: wr_addr+1, wr_count+1, lfsr steps once. If the accepted word was number N_INSTR-2 (0-based), go to HALT.
  - HALT: wr_valid=1, wr_data=32'h4000_0000 | last address, i.e. T=01, OPC=000 jump-to-self. On accept go to DONE.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
- Handshake: while wr_valid && !wr_ready, wr_addr, wr_data and lfsr hold stable. Data is registered and there is no combinational path from wr_ready to wr_data. Sustained throughput is 1 word/cycle.
- LFSR: 32-bit Galois, right shift: next = (s>>1) ^ (s[0] ? 32'h8020_0003 : 0).
- fmt(s): fields are copied from s, then legalised.
  - T=s[31:30], OPC=s[29:27], regA=s[26:22], regB=s[21:17], regC=s[16:12], bits[11:8]=0, imm=s[7:0].
  - MOVEMENT OPC map {0,1,2,3,4,0,1,2}.
  - LOGIC OPC map {0,1,2,0,1,2,0,1}.
  - ARITHMETIC OPC = s[28:27] (0..3).
  - FLOWCTRL (when enabled): all OPCs are legal. imm = min(wr_addr+1+s[3:0], halt address), so targets are forward only and the program cannot loop.
  - load/store/storei imm is used unchanged as the data address.
- start asserted in the same cycle as done is ignored.

Optional Feature:
- Macro: RIGEN_FLOWCTRL_EN.
- Defined: T=01 words are generated with forward-clamped targets as above.
- Undefined: any T=01 from the LFSR is rewritten to T=10 (LOGIC) with the LOGIC OPC map. Only the halt word carries T=01. Straight-line programs result.

Decomposition:
- Shared package rigen_pkg holds:
  - T codes MOVEMENT/LOGIC/ARITHMETIC/FLOWCTRL and all OPC constants;
  - the state enum;
  - the LFSR polynomial constant;
  - the field bit positions;
  - the function legalise_opc(T, opc).
- One sub-module, rigen_lfsr (seed, step enable, 32-bit state), is reused by the bench's reference scoreboard.

Test Plan:
1. SEED=1, wr_ready=1, pulse start → first accepted word addr 0x00, data 0x0000_0001; the second word equals fmt(0x8020_0003) after legalisation.
2. N_INSTR=4, BASE_ADDR=0x10, wr_ready=1 → writes at 0x10, 0x11, 0x12, then 0x4000_0013 at 0x13. done pulses 1 cycle after the last accept; wr_count=4.
3. Drop wr_ready for 3 cycles mid-stream → wr_addr/wr_data stable for all 3 cycles; the sequence after resume is identical to the no-stall run.
4. Assert rst while wr_count=5 → all outputs return to reset values within the same cycle. A new start reproduces the run from SEED.
5. SEED=0 → output stream is bit-identical to the SEED=1 run.
6. N_INSTR=200, 50 random wr_ready patterns, per macro setting:
   - every word decodes to a legal T/OPC;
   - with RIGEN_FLOWCTRL_EN off, no T=01 word appears except the final one;
   - with it on, every flow target is greater than its own address and at most the halt address.

Source files
------------

// File: rtl/rigen_pkg.sv
// Shared encodings for the random instruction generator: field layout, opcode
// classes, FSM states, LFSR polynomial and opcode legalisation.
package rigen_pkg;

  typedef enum logic [1:0] {
    T_MOVEMENT   = 2'b00,
    T_FLOWCTRL   = 2'b01,
    T_LOGIC      = 2'b10,
    T_ARITHMETIC = 2'b11
  } t_code_e;

  typedef enum logic [2:0] {
    OPC_MOV    = 3'd0,
    OPC_MOVI   = 3'd1,
    OPC_LOAD   = 3'd2,
    OPC_STORE  = 3'd3,
    OPC_STOREI = 3'd4
  } mov_opc_e;

  typedef enum logic [2:0] {
    OPC_AND = 3'd0,
    OPC_OR  = 3'd1,
    OPC_NOT = 3'd2
  } logic_opc_e;

  typedef enum logic [2:0] {
    OPC_ADD = 3'd0,
    OPC_SUB = 3'd1,
    OPC_INC = 3'd2,
    OPC_DEC = 3'd3
  } arith_opc_e;

  // Every flow-control opcode is legal; OPC_JMP is the one the halt word uses.
  typedef enum logic [2:0] {
    OPC_JMP = 3'd0
  } flow_opc_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GEN,
    ST_HALT,
    ST_DONE
  } state_t;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  localparam int F_T_MSB   = 31;
  localparam int F_T_LSB   = 30;
  localparam int F_OPC_MSB = 29;
  localparam int F_OPC_LSB = 27;
  localparam int F_RA_MSB  = 26;
  localparam int F_RA_LSB  = 22;
  localparam int F_RB_MSB  = 21;
  localparam int F_RB_LSB  = 17;
  localparam int F_RC_MSB  = 16;
  localparam int F_RC_LSB  = 12;
  localparam int F_IMM_MSB = 7;
  localparam int F_IMM_LSB = 0;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

  // Folds an out-of-range opcode back onto the legal set of its class.
  function automatic logic [2:0] legalise_opc(input logic [1:0] t, input logic [2:0] opc);
    logic [2:0] r;
    r = opc;
    case (t)
      T_MOVEMENT: begin
        case (opc)
          3'd5:    r = OPC_MOV;
          3'd6:    r = OPC_MOVI;
          3'd7:    r = OPC_LOAD;
          default: r = opc;
        endcase
      end
      T_LOGIC: begin
        case (opc)
          3'd3, 3'd6: r = OPC_AND;
          3'd4, 3'd7: r = OPC_OR;
          3'd5:       r = OPC_NOT;
          default:    r = opc;
        endcase
      end
      T_ARITHMETIC: begin
        case (opc[1:0])
          2'd0:    r = OPC_ADD;
          2'd1:    r = OPC_SUB;
          2'd2:    r = OPC_INC;
          default: r = OPC_DEC;
        endcase
      end
      default: r = opc;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rigen_lfsr.sv
// 32-bit right-shifting Galois LFSR; a zero SEED is replaced by 1 so the
// register can never lock up in the all-zero state.
module rigen_lfsr
  import rigen_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  output logic [31:0] state
);

  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       state <= SEED_EFF;
    else if (step) state <= lfsr_next(state);
  end

endmodule

// File: rtl/rand_instr_gen.sv
// Writes N_INSTR legal random instructions ending in a self-jump halt into
// instruction memory. Define RIGEN_FLOWCTRL_EN to emit forward-only jumps.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; address parked at BASE_ADDR
// GEN     | presenting random words, one per accept
// HALT    | presenting the jump-to-self word at the last address
// DONE    | one-cycle completion pulse, then back to IDLE
module rand_instr_gen
  import rigen_pkg::*;
#(
  parameter int          N_INSTR   = 200,
  parameter logic [7:0]  BASE_ADDR = 8'h00,
  parameter logic [31:0] SEED      = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [7:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic [7:0]  wr_count
);

  if ((N_INSTR < 2) || (N_INSTR > 256) || (int'(BASE_ADDR) + N_INSTR > 256)) begin : g_param_check
    $error("rand_instr_gen: N_INSTR must be 2..256 and BASE_ADDR+N_INSTR <= 256");
  end

  localparam logic [7:0]  HALT_ADDR = 8'(int'(BASE_ADDR) + N_INSTR - 1);
  localparam logic [7:0]  LAST_GEN  = 8'(N_INSTR - 2);
  localparam logic [31:0] HALT_WORD = {T_FLOWCTRL, OPC_JMP, 15'h0, 4'h0, HALT_ADDR};

  state_t      state, state_nxt;
  logic [31:0] lfsr_q;
  logic        accept;
  logic        last_gen;

  function automatic logic [31:0] fmt_word(input logic [31:0] s, input logic [7:0] addr);
    logic [31:0] w;
    logic [1:0]  t;
    logic [7:0]  imm;
`ifdef RIGEN_FLOWCTRL_EN
    logic [8:0]  tgt;
`else
    logic        unused_addr;
`endif
    t   = s[F_T_MSB:F_T_LSB];
    imm = s[F_IMM_MSB:F_IMM_LSB];
`ifdef RIGEN_FLOWCTRL_EN
    // Forward-only targets clamped to the halt word keep every program finite.
    tgt = {1'b0, addr} + 9'd1 + {5'b0, s[3:0]};
    if (t == T_FLOWCTRL)
      imm = (tgt > {1'b0, HALT_ADDR}) ? HALT_ADDR : tgt[7:0];
`else
    unused_addr = ^addr;
    if (t == T_FLOWCTRL) t = T_LOGIC;
`endif
    w = '0;
    w[F_T_MSB:F_T_LSB]     = t;
    w[F_OPC_MSB:F_OPC_LSB] = legalise_opc(t, s[F_OPC_MSB:F_OPC_LSB]);
    w[F_RA_MSB:F_RA_LSB]   = s[F_RA_MSB:F_RA_LSB];
    w[F_RB_MSB:F_RB_LSB]   = s[F_RB_MSB:F_RB_LSB];
    w[F_RC_MSB:F_RC_LSB]   = s[F_RC_MSB:F_RC_LSB];
    w[F_IMM_MSB:F_IMM_LSB] = imm;
    return w;
  endfunction

  assign accept   = wr_valid && wr_ready;
  assign last_gen = (wr_count == LAST_GEN);

  rigen_lfsr #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  ((state == ST_GEN) && accept),
    .state (lfsr_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_GEN;
      ST_GEN:  if (accept && last_gen) state_nxt = ST_HALT;
      ST_HALT: if (accept) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_valid = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      ST_GEN, ST_HALT: begin
        wr_valid = 1'b1;
        busy     = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // The next word is formatted one cycle ahead so wr_data is a plain register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr  <= BASE_ADDR;
      wr_data  <= '0;
      wr_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          wr_addr <= BASE_ADDR;
          if (start) begin
            wr_count <= '0;
            wr_data  <= fmt_word(lfsr_q, BASE_ADDR);
          end
        end
        ST_GEN: begin
          if (accept) begin
            wr_addr  <= wr_addr + 8'd1;
            wr_count <= wr_count + 8'd1;
            wr_data  <= last_gen ? HALT_WORD : fmt_word(lfsr_next(lfsr_q), wr_addr + 8'd1);
          end
        end
        ST_HALT: begin
          if (accept) begin
            wr_count <= wr_count + 8'd1;
            wr_data  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
